con_dump_ctrl: RTL and testbench
================================

# con_dump_ctrl

Protocol-side controller that reads vector data memory through the controller port (`con_addr`/`con_out`/`con_write`/`con_in`) and streams the contents out as a big-endian byte stream to a serial transmitter (e.g. a UART TX). It sits between the vector data memory and the host link. It walks a programmed word range, holds each address across the memory's one-cycle synchronous read, and shifts the word out byte by byte under a valid/ready handshake. On completion it writes a status word into the protocol mailbox region.

## Interface
Parameters:
- `ADDR_BITS`, 14: con port address width; equals `DATAMEM_BITS`.
- `STATUS_ADDR`, 14'h200F: mailbox word address that receives the completion status.
- `STATUS_TAG`, 8'hA5: upper byte of the status word.

Ports:
- `con_clk` in 1: single clock; all logic on rising edge.
- `nrst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; accepted only when `busy`=0.
- `start_addr` in 14: first word address; bit 13 ignored (core memory only).
- `word_count` in 14: words to send, 0..8192.
- `abort` in 1: stop at the next word boundary.
- `con_addr` out 14: address to the data memory controller port.
- `con_write` out 4: byte write enables to the controller port.
- `con_in` out 32: write data, big-endian.
- `con_out` in 32: read data, big-endian, valid one cycle after `con_addr` is presented and held.
- `tx_data` out 8: byte to the transmitter.
- `tx_valid` out 1: `tx_data` valid.
- `tx_ready` in 1: transmitter accepts the byte.
- `busy` out 1: high from start acceptance through the DONE cycle.
- `done` out 1: one-cycle pulse at the end of the transfer.

## Operation
- States: IDLE, RD, CAP, SEND, STATUS, DONE.
- IDLE: `start` latches `cur_addr={1'b0,start_addr[12:0]}`, `remaining=word_count`, and `sent=0`, and clears `abort_pend`.
  - If `word_count`=0, next state is STATUS; otherwise next state is RD.
- RD: `con_addr=cur_addr`. Next state is CAP.
- CAP: `con_addr` still equals `cur_addr`. This is required because the memory bank mux uses the live `con_addr[1:0]`. `con_out` is latched into a 32-bit shift register. Next state is SEND.
- SEND: `tx_valid`=1 and `tx_data=shreg[31:24]`.
  - On `tx_valid&&tx_ready`: shift left by 8 and increment the 2-bit byte counter.
  - After the 4th accepted byte: `sent++` and `remaining--`.
  - If `remaining` reaches 0 or `abort_pend`=1, next state is STATUS.
  - Otherwise `cur_addr` increments modulo 0x2000 (0x1FFF wraps to 0x0000) and next state is RD.
- `abort`: setting `abort_pend` while `busy` has no effect mid-word. It is checked only at word end, in the SEND→STATUS decision.
- STATUS: for exactly one cycle, `con_addr=STATUS_ADDR`, `con_write=4'hF`, `con_in={STATUS_TAG,10'b0,sent[13:0]}`. Next state is DONE.
- DONE: `done`=1 for one cycle. Next state is IDLE, where `busy`=0.
- `start` while `busy`=1 is ignored.
- `con_write` is 0 in every state except STATUS. `con_in` is 0 outside STATUS.
- Byte order: `con_out[31:24]` is sent first.

## Timing
- Reset (asynchronous, immediate): state=IDLE; `con_addr`=0, `con_write`=0, `con_in`=0, `tx_data`=0, `tx_valid`=0, `busy`=0, `done`=0; all counters cleared. Reset mid-transfer discards the partial word.
- Outputs are registered or decoded from registered state only. No combinational path from `tx_ready` to `tx_valid`.
- `start` accepted at edge E0: `busy` is high from E0. RD occupies cycle E0–E1 and CAP occupies E1–E2. `tx_valid` rises after E2.
- With `tx_ready` held at 1: each word takes 6 cycles (RD, CAP, 4×SEND).
- `word_count`=0: STATUS in the cycle after E0, DONE in the next, `busy` low after 3 edges.
- While `tx_valid`=1 and `tx_ready`=0: `tx_data` is held stable and `tx_valid` does not drop.
- Simultaneous `abort` and the 4th byte handshake: that word counts as sent, then STATUS.

## Test plan
- Preload 0x0010=0x11223344 and 0x0011=0xAABBCCDD; start 0x0010, count 2, `tx_ready`=1 -> bytes 11 22 33 44 AA BB CC DD in 12 consecutive cycles -> one STATUS cycle with `con_write`=F, `con_addr`=0x200F, `con_in`=0xA5000002 -> `done` pulse -> `busy` low.
- Same transfer with `tx_ready` toggling 1,0,0,1 -> identical byte sequence; `tx_data` constant while stalled; no byte lost or duplicated.
- Start 0x1FFF, count 2 -> `con_addr` sequence 0x1FFF then 0x0000; `con_addr` held for both RD and CAP of each word.
- Count 0 -> `tx_valid` never asserts; status 0xA5000000 written; `done` 2 cycles after start acceptance.
- Count 4, `abort` pulsed during the 2nd byte of word 2 -> word 2 fully sent (8 bytes total), status 0xA5000002; `start` during the transfer ignored.
- `nrst` low mid-SEND -> all outputs 0 immediately; after release, a new start of 1 word completes normally.

Source files
------------

// File: rtl/con_dump_ctrl.sv
// con_dump_ctrl: walks a word range of vector data memory over the controller
// port, streams each word out MSB byte first on a valid/ready byte interface,
// then writes a completion status word into the protocol mailbox.
module con_dump_ctrl #(
  parameter int                  ADDR_BITS   = 14,
  parameter logic [ADDR_BITS-1:0] STATUS_ADDR = 14'h200F,
  parameter logic [7:0]          STATUS_TAG  = 8'hA5
) (
  input  logic                 con_clk,
  input  logic                 nrst,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] start_addr,
  input  logic [ADDR_BITS-1:0] word_count,
  input  logic                 abort,
  output logic [ADDR_BITS-1:0] con_addr,
  output logic [3:0]           con_write,
  output logic [31:0]          con_in,
  input  logic [31:0]          con_out,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    CAP    = 3'd2,
    SEND   = 3'd3,
    STATUS = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Top address bit selects the mailbox region; the dump only covers core memory.
  localparam logic [ADDR_BITS-1:0] CORE_MASK = {1'b0, {(ADDR_BITS-1){1'b1}}};

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   cur_addr;
  logic [ADDR_BITS-1:0]   remaining;
  logic [ADDR_BITS-1:0]   sent;
  logic [1:0]             byte_cnt;
  logic                   abort_pend;
  logic [31:0]            shreg;
  logic                   hs;
  logic                   word_end;
  logic                   last_word;

  assign hs        = (state_q == SEND) && tx_ready;
  assign word_end  = hs && (byte_cnt == 2'd3);
  // A live abort coinciding with the final byte still ends after this word.
  assign last_word = (remaining == {{(ADDR_BITS-1){1'b0}}, 1'b1}) || abort_pend || abort;

  // State register.
  always_ff @(posedge con_clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = (word_count == '0) ? STATUS : RD;
      RD:     state_d = CAP;
      CAP:    state_d = SEND;
      SEND:   if (word_end) state_d = last_word ? STATUS : RD;
      STATUS: state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transfer bookkeeping: address, word counters, byte counter, pending abort.
  always_ff @(posedge con_clk or negedge nrst) begin
    if (!nrst) begin
      cur_addr   <= '0;
      remaining  <= '0;
      sent       <= '0;
      byte_cnt   <= 2'd0;
      abort_pend <= 1'b0;
    end else if (state_q == IDLE) begin
      if (start) begin
        cur_addr   <= start_addr & CORE_MASK;
        remaining  <= word_count;
        sent       <= '0;
        byte_cnt   <= 2'd0;
        abort_pend <= 1'b0;
      end
    end else begin
      if (abort) abort_pend <= 1'b1;
      if (hs)    byte_cnt   <= byte_cnt + 2'd1;
      if (word_end) begin
        sent      <= sent + 1'b1;
        remaining <= remaining - 1'b1;
        cur_addr  <= (cur_addr + 1'b1) & CORE_MASK;
      end
    end
  end

  // Byte shifter: loaded from memory in CAP, advanced one byte per handshake.
  always_ff @(posedge con_clk) begin
    if (state_q == CAP) shreg <= con_out;
    else if (hs)        shreg <= {shreg[23:0], 8'h00};
  end

  // Outputs decoded from registered state only.
  always_comb begin
    con_addr  = '0;
    con_write = 4'h0;
    con_in    = 32'h0;
    tx_data   = 8'h00;
    tx_valid  = 1'b0;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    case (state_q)
      RD, CAP: con_addr = cur_addr;
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = shreg[31:24];
      end
      STATUS: begin
        con_addr  = STATUS_ADDR;
        con_write = 4'hF;
        con_in    = {STATUS_TAG, {(24-ADDR_BITS){1'b0}}, sent};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_con_dump_ctrl.sv
// Bench for con_dump_ctrl: memory model with address-hold dependent read data,
// byte and status scoreboards, and directed timing checks.
module tb_con_dump_ctrl;

  logic        con_clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start = 1'b0;
  logic [13:0] start_addr = '0;
  logic [13:0] word_count = '0;
  logic        abort = 1'b0;
  logic [13:0] con_addr;
  logic [3:0]  con_write;
  logic [31:0] con_in;
  logic [31:0] con_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        busy;
  logic        done;

  con_dump_ctrl dut (
    .con_clk(con_clk), .nrst(nrst), .start(start), .start_addr(start_addr),
    .word_count(word_count), .abort(abort), .con_addr(con_addr),
    .con_write(con_write), .con_in(con_in), .con_out(con_out),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  always #5 con_clk = ~con_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int first_hs = -1;
  int last_hs = -1;
  int status_cyc = -1;
  int done_cyc = -1;
  int rdy_mode = 0;
  bit seen_valid = 1'b0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  logic [31:0] mem [0:8191];
  logic [13:0] addr_q = '0;
  logic [7:0]  byte_q [$];
  logic [31:0] status_q [$];

  // Synchronous-read memory; data is only meaningful if the address is held.
  always @(posedge con_clk) addr_q <= con_addr;
  assign con_out = (con_addr == addr_q) ? mem[addr_q[12:0]] : 32'hDEADBEEF;

  always @(posedge con_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Ready driver: always ready, or a repeating 1,0,0,1 pattern.
  initial begin
    int k = 0;
    forever begin
      @(posedge con_clk);
      #1;
      k++;
      tx_ready = (rdy_mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
    end
  end

  // Monitor: byte and status scoreboards, stall stability, timing capture.
  always @(negedge con_clk) begin
    if (!nrst) begin
      prev_stall = 1'b0;
    end else begin
      if (tx_valid) seen_valid = 1'b1;
      if (prev_stall) begin
        check("stall_valid", {31'b0, tx_valid}, 32'd1);
        check("stall_data", {24'b0, tx_data}, {24'b0, prev_data});
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (tx_valid && tx_ready) begin
        if (first_hs < 0) first_hs = cyc + 1;
        last_hs = cyc + 1;
        if (byte_q.size() == 0) check("byte_extra", {24'b0, tx_data}, 32'hFFFF_FFFF);
        else check("byte", {24'b0, tx_data}, {24'b0, byte_q.pop_front()});
      end
      if (con_write != 4'h0) begin
        status_cyc = cyc;
        if (status_q.size() == 0) check("status_extra", con_in, 32'hFFFF_FFFF);
        else begin
          check("st_we", {28'b0, con_write}, 32'hF);
          check("st_addr", {18'b0, con_addr}, 32'h200F);
          check("st_data", con_in, status_q.pop_front());
        end
      end else begin
        check("con_in_idle", con_in, 32'h0);
      end
      if (done) done_cyc = cyc;
    end
  end

  task automatic push_words(input logic [13:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      logic [12:0] ad;
      logic [31:0] w;
      ad = a[12:0] + 13'(i);
      w  = mem[ad];
      byte_q.push_back(w[31:24]);
      byte_q.push_back(w[23:16]);
      byte_q.push_back(w[15:8]);
      byte_q.push_back(w[7:0]);
    end
  endtask

  task automatic kick(input logic [13:0] a, input logic [13:0] n);
    first_hs = -1; last_hs = -1; status_cyc = -1; done_cyc = -1;
    @(posedge con_clk); #1;
    start = 1'b1; start_addr = a; word_count = n;
    @(posedge con_clk); #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge con_clk);
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
    @(posedge con_clk); #1;
    check({tag, "_busy_low"}, {31'b0, busy}, 32'd0);
    check({tag, "_bytes_left"}, byte_q.size(), 32'd0);
    check({tag, "_status_left"}, status_q.size(), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_con_addr"}, {18'b0, con_addr}, 32'd0);
    check({tag, "_con_write"}, {28'b0, con_write}, 32'd0);
    check({tag, "_con_in"}, con_in, 32'd0);
    check({tag, "_tx_data"}, {24'b0, tx_data}, 32'd0);
    check({tag, "_tx_valid"}, {31'b0, tx_valid}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = $urandom;
    mem[13'h0010] = 32'h11223344;
    mem[13'h0011] = 32'hAABBCCDD;
    mem[13'h1FFF] = 32'h01020304;
    mem[13'h0000] = 32'hF0E0D0C0;

    #1;
    check_outputs_zero("reset");
    #20;
    @(negedge con_clk);
    nrst = 1'b1;

    // Two words, always ready: back-to-back timing.
    rdy_mode = 0;
    push_words(14'h0010, 2);
    status_q.push_back(32'hA5000002);
    kick(14'h0010, 14'd2);
    wait_done("t1");
    check("t1_first_hs", first_hs - start_cyc, 32'd3);
    check("t1_last_hs", last_hs - start_cyc, 32'd12);
    check("t1_status_cyc", status_cyc - start_cyc, 32'd12);
    check("t1_done_cyc", done_cyc - start_cyc, 32'd13);

    // Same transfer with back-pressure.
    rdy_mode = 1;
    push_words(14'h0010, 2);
    status_q.push_back(32'hA5000002);
    kick(14'h0010, 14'd2);
    wait_done("t2");

    // Address wrap 0x1FFF -> 0x0000, address held across RD and CAP.
    rdy_mode = 0;
    push_words(14'h1FFF, 2);
    status_q.push_back(32'hA5000002);
    kick(14'h1FFF, 14'd2);
    check("t3_rd0", {18'b0, con_addr}, 32'h1FFF);
    @(posedge con_clk); #1;
    check("t3_cap0", {18'b0, con_addr}, 32'h1FFF);
    repeat (5) @(posedge con_clk);
    #1;
    check("t3_rd1", {18'b0, con_addr}, 32'h0000);
    check("t3_rd1_busy", {31'b0, busy}, 32'd1);
    @(posedge con_clk); #1;
    check("t3_cap1", {18'b0, con_addr}, 32'h0000);
    wait_done("t3");

    // Zero-length transfer.
    seen_valid = 1'b0;
    status_q.push_back(32'hA5000000);
    kick(14'h0010, 14'd0);
    check("t4_status_we", {28'b0, con_write}, 32'hF);
    check("t4_busy", {31'b0, busy}, 32'd1);
    @(posedge con_clk); #1;
    check("t4_done", {31'b0, done}, 32'd1);
    @(posedge con_clk); #1;
    check("t4_done_low", {31'b0, done}, 32'd0);
    check("t4_busy_low", {31'b0, busy}, 32'd0);
    check("t4_no_valid", {31'b0, seen_valid}, 32'd0);
    check("t4_status_left", status_q.size(), 32'd0);

    // Abort during the 2nd byte of word 2; a start mid-transfer is ignored.
    for (int i = 0; i < 4; i++) mem[13'h0020 + 13'(i)] = 32'hC0DE0000 + 32'(i);
    push_words(14'h0020, 2);
    status_q.push_back(32'hA5000002);
    kick(14'h0020, 14'd4);
    repeat (3) @(posedge con_clk);
    #1;
    start = 1'b1; start_addr = 14'h0100; word_count = 14'd5;
    @(posedge con_clk); #1;
    start = 1'b0;
    repeat (5) @(posedge con_clk);
    #1;
    abort = 1'b1;
    @(posedge con_clk); #1;
    abort = 1'b0;
    wait_done("t5");

    // Reset in the middle of SEND, then a fresh one-word transfer.
    push_words(14'h0010, 2);
    status_q.push_back(32'hA5000002);
    kick(14'h0010, 14'd2);
    repeat (3) @(posedge con_clk);
    #2;
    nrst = 1'b0;
    #1;
    check_outputs_zero("t6_rst");
    byte_q.delete();
    status_q.delete();
    repeat (2) @(posedge con_clk);
    #3;
    nrst = 1'b1;
    push_words(14'h0011, 1);
    status_q.push_back(32'hA5000001);
    kick(14'h0011, 14'd1);
    wait_done("t6");
    check("t6_first_hs", first_hs - start_cyc, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
